fetch_stage: RTL

//  Instruction-fetch stage plus IF/ID pipeline register, directly upstream of decode/control.

---
 rtl/fetch_stage_if.sv | 9 +
 rtl/fetch_stage.sv | 86 ++++++++
 2 files changed

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: req/ack instruction-memory handshake between fetch stage and memory
interface fetch_stage_if;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;
    modport master(output req, addr, input ack, rdata);
    modport slave(input req, addr, output ack, rdata);
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: PC owner, variable-latency imem handshake and IF/ID pipeline register
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 stall_i,
    input  logic                 flush_i,
    input  logic [31:0]          branch_target_i,
    fetch_stage_if.master        imem,
    output logic                 if_valid_o,
    output logic [31:0]          if_inst_o,
    output logic [31:0]          if_pc4_o
);
    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

    state_t      state_q;
    logic [31:0] pc_q, redir_pc_q, hold_inst_q, hold_pc4_q, if_inst_q, if_pc4_q;
    logic        redir_pend_q, if_valid_q;
    logic [31:0] pc4_d, target_d;

    assign pc4_d      = pc_q + 32'd4;
    assign target_d   = {branch_target_i[31:2], 2'b00};
    assign imem.req   = state_q == FETCH;
    assign imem.addr  = pc_q;
    assign if_valid_o = if_valid_q;
    assign if_inst_o  = if_inst_q;
    assign if_pc4_o   = if_pc4_q;

    // Fetch FSM: a flush seen while waiting is remembered so the in-flight word is discarded on ack
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            redir_pend_q <= 1'b0;
            redir_pc_q   <= 32'h0;
            hold_inst_q  <= 32'h0;
            hold_pc4_q   <= 32'h0;
            if_valid_q   <= 1'b0;
            if_inst_q    <= 32'h0;
            if_pc4_q     <= 32'h0;
        end else begin
            case (state_q)
                IDLE: state_q <= FETCH;
                FETCH: begin
                    if (imem.ack) begin
                        if (flush_i || redir_pend_q) begin
                            pc_q         <= flush_i ? target_d : redir_pc_q;
                            redir_pend_q <= 1'b0;
                            if_valid_q   <= 1'b0;
                        end else if (stall_i) begin
                            hold_inst_q <= imem.rdata;
                            hold_pc4_q  <= pc4_d;
                            pc_q        <= pc4_d;
                            state_q     <= HOLD;
                        end else begin
                            if_inst_q  <= imem.rdata;
                            if_pc4_q   <= pc4_d;
                            if_valid_q <= 1'b1;
                            pc_q       <= pc4_d;
                        end
                    end else begin
                        if (flush_i) begin
                            redir_pend_q <= 1'b1;
                            redir_pc_q   <= target_d;
                        end
                        if (!stall_i || flush_i) if_valid_q <= 1'b0;
                    end
                end
                HOLD: begin
                    if (flush_i) begin
                        pc_q       <= target_d;
                        if_valid_q <= 1'b0;
                        state_q    <= FETCH;
                    end else if (!stall_i) begin
                        if_inst_q  <= hold_inst_q;
                        if_pc4_q   <= hold_pc4_q;
                        if_valid_q <= 1'b1;
                        state_q    <= FETCH;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
